// File: rtl/core_cc_pkg.sv
// Shared SEC-DED helpers for the core-cc datapath: geometry of the extended
// Hamming codeword and the data-bit position map, used by encoder and decoder.
package core_cc_pkg;

  typedef enum logic [1:0] {
    R_CLEAN,
    R_PARITY,
    R_SINGLE,
    R_DOUBLE
  } secded_result_e;

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest p with 2^p >= dw + p + 1; descending scan leaves the smallest hit.
  function automatic int unsigned secded_p(input int unsigned dw);
    int unsigned p;
    p = 8;
    for (int unsigned k = 8; k >= 1; k--) begin
      if ((32'd1 << k) >= dw + k + 1) p = k;
    end
    return p;
  endfunction

  function automatic int unsigned secded_cw_w(input int unsigned dw);
    return dw + secded_p(dw) + 1;
  endfunction

  // Hamming position of data bit j: the (j+1)-th non-power-of-two position.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned i = 1; i < 256; i++) begin
      if (!is_pow2(i)) begin
        if (cnt == j && pos == 0) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_syndrome.sv
// Combinational syndrome/overall-parity generator for an extended Hamming codeword.
module hamming_syndrome #(
  parameter int unsigned CW_W = 13,
  parameter int unsigned P    = 4
) (
  input  logic [CW_W-1:0] cw,
  output logic [P-1:0]    s,
  output logic            q
);

  always_comb begin
    s = '0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if (cw[i]) s = s ^ P'(i);
    end
    q = ^cw;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming SEC-DED decoder with valid/ready
// streaming and saturating SEC/DED event counters.
module hamming_secded_decoder
  import core_cc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned P      = secded_p(DATA_W),
  parameter int unsigned CW_W   = secded_cw_w(DATA_W),
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [P-1:0]      out_syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  localparam logic [P-1:0] S_MAX = P'(CW_W - 1);

  logic              adv1;
  logic              adv2;
  logic [P-1:0]      syn;
  logic              par;
  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [P-1:0]      s1_s;
  logic              s1_q;
  secded_result_e    res;
  logic [CW_W-1:0]   fixed;
  logic [DATA_W-1:0] corr_data;
  logic              hs_out;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign hs_out   = out_valid && out_ready;

  hamming_syndrome #(
    .CW_W (CW_W),
    .P    (P)
  ) u_syndrome (
    .cw (in_cw),
    .s  (syn),
    .q  (par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_s     <= '0;
      s1_q     <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw <= in_cw;
        s1_s  <= syn;
        s1_q  <= par;
      end
    end
  end

  always_comb begin
    res = R_CLEAN;
    if (s1_q) begin
      if (s1_s == '0)        res = R_PARITY;
      else if (s1_s <= S_MAX) res = R_SINGLE;
      else                   res = R_DOUBLE;
    end else if (s1_s != '0) begin
      res = R_DOUBLE;
    end
  end

  always_comb begin
    fixed = s1_cw;
    if (res == R_SINGLE) begin
      for (int unsigned i = 1; i < CW_W; i++) begin
        if (s1_s == P'(i)) fixed[i] = ~fixed[i];
      end
    end
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    localparam int unsigned POS = data_pos(j);
    assign corr_data[j] = fixed[POS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= corr_data;
        out_sec      <= (res == R_PARITY) || (res == R_SINGLE);
        out_ded      <= (res == R_DOUBLE);
        out_syndrome <= s1_s;
      end
    end
  end

  // Clear takes priority over a coincident counted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (clr_cnt) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (hs_out) begin
      if (out_sec && sec_count != '1) sec_count <= sec_count + 1'b1;
      if (out_ded && ded_count != '1) ded_count <= ded_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=8): table vectors,
// randomized error injection against an encode/inject model, flow-control corners.
module tb_hamming_secded_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_cw = '0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        in_ready, out_valid, out_sec, out_ded;
  logic [7:0]  out_data;
  logic [3:0]  out_syndrome;
  logic [15:0] sec_count, ded_count;

  logic        in_ready_s, out_valid_s, out_sec_s, out_ded_s;
  logic [7:0]  out_data_s;
  logic [3:0]  out_syndrome_s;
  logic [1:0]  sec_count_s, ded_count_s;

  hamming_secded_decoder #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
    .out_ded(out_ded), .out_syndrome(out_syndrome), .clr_cnt(clr_cnt),
    .sec_count(sec_count), .ded_count(ded_count));

  hamming_secded_decoder #(.DATA_W(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_cw(in_cw),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_sec(out_sec_s),
    .out_ded(out_ded_s), .out_syndrome(out_syndrome_s), .clr_cnt(clr_cnt),
    .sec_count(sec_count_s), .ded_count(ded_count_s));

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] cw;
    logic [7:0]  data;
    logic        sec;
    logic        ded;
    logic [3:0]  syn;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_sec = 0;
  int          m_ded = 0;
  int unsigned dpos[8];
  bit          bp_track = 0;
  int          stamps[$];
  bit          h_hold = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] cw;
    logic [3:0]  s;
    cw = '0;
    s  = '0;
    for (int j = 0; j < 8; j++) cw[dpos[j]] = d[j];
    for (int i = 1; i < 13; i++) if (cw[i]) s = s ^ 4'(i);
    for (int k = 0; k < 4; k++) if (s[k]) cw[1 << k] = 1'b1;
    cw[0] = ^cw[12:1];
    return cw;
  endfunction

  function automatic logic [7:0] extract(input logic [12:0] cw);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = cw[dpos[j]];
    return d;
  endfunction

  function automatic exp_t mk(input logic [12:0] cw, input logic [7:0] d,
                              input logic sec, input logic ded, input logic [3:0] syn);
    exp_t e;
    e.cw = cw; e.data = d; e.sec = sec; e.ded = ded; e.syn = syn;
    return e;
  endfunction

  // Encode clean data, then inject 0, 1 or 2 distinct bit flips.
  function automatic exp_t make_word(input logic [7:0] d, input int nflip);
    exp_t e;
    int a, b;
    e = mk(encode(d), d, 1'b0, 1'b0, 4'd0);
    if (nflip == 1) begin
      a = $urandom_range(0, 12);
      e.cw[a] = ~e.cw[a];
      e.sec = 1'b1;
      e.syn = 4'(a);
    end else if (nflip == 2) begin
      a = $urandom_range(0, 12);
      b = (a + $urandom_range(1, 12)) % 13;
      e.cw[a] = ~e.cw[a];
      e.cw[b] = ~e.cw[b];
      e.ded = 1'b1;
      e.syn = 4'(a ^ b);
      e.data = extract(e.cw);
    end
    return e;
  endfunction

  task automatic send(input exp_t e, input bit rnd);
    bit done;
    int guard;
    done = 0;
    guard = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cw = e.cw;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end else if (++guard > 200) begin
        chk("send_timeout_in_ready", in_ready, 1);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Output monitor: scoreboard, hold stability, counter model.
  initial begin
    exp_t e;
    logic [7:0] h_data;
    logic [3:0] h_syn;
    logic h_sec, h_ded;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("sec_count", sec_count, sat(m_sec, 65535));
        chk("ded_count", ded_count, sat(m_ded, 65535));
        chk("sat_sec_count", sec_count_s, sat(m_sec, 3));
        chk("sat_ded_count", ded_count_s, sat(m_ded, 3));
        if (h_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, h_data);
          chk("hold_flags", {out_sec, out_ded, out_syndrome}, {h_sec, h_ded, h_syn});
        end
        h_hold = out_valid && !out_ready;
        h_data = out_data; h_sec = out_sec; h_ded = out_ded; h_syn = out_syndrome;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("out_valid_with_nothing_expected", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_sec", out_sec, e.sec);
            chk("out_ded", out_ded, e.ded);
            chk("out_syndrome", out_syndrome, e.syn);
            if (bp_track) stamps.push_back(cyc);
            if (!clr_cnt) begin
              m_sec += int'(e.sec);
              m_ded += int'(e.ded);
            end
          end
        end
        if (clr_cnt) begin
          m_sec = 0;
          m_ded = 0;
        end
      end else begin
        h_hold = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t tbl[7];
    exp_t w[6];
    int k;
    k = 0;
    for (int i = 1; i < 13; i++) if ($countones(i) != 1) dpos[k++] = i;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags_syn", {out_sec, out_ded, out_syndrome}, 0);
    chk("rst_counts", {sec_count, ded_count}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Latency: out_valid rises exactly two edges after the accepting edge.
    @(negedge clk);
    in_valid = 1'b1;
    in_cw = 13'h144E;
    #1;
    chk("lat_in_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(mk(13'h144E, 8'hA5, 0, 0, 4'd0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lat_valid_cycle1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_valid_cycle2", out_valid, 1);
    idle(3);

    tbl[0] = mk(13'h144E, 8'hA5, 0, 0, 4'd0);
    tbl[1] = mk(13'h140E, 8'hA5, 1, 0, 4'd6);
    tbl[2] = mk(13'h144F, 8'hA5, 1, 0, 4'd0);
    tbl[3] = mk(13'h1466, 8'hA6, 0, 1, 4'd6);
    tbl[4] = mk(13'h155C, 8'hA5, 0, 1, 4'd13);
    tbl[5] = mk(13'h0000, 8'h00, 0, 0, 4'd0);
    tbl[6] = mk(13'h044E, 8'hA5, 1, 0, 4'd12);
    for (int i = 0; i < 7; i++) send(tbl[i], 0);
    idle(4);
    chk("tbl_sec_count", sec_count, 3);
    chk("tbl_ded_count", ded_count, 2);

    // Full backpressure: two words fit, then in_ready drops.
    for (int i = 0; i < 6; i++) w[i] = make_word(8'($urandom), 0);
    out_ready = 1'b0;
    k = 0;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cw = w[(k < 6) ? k : 5].cw;
      #1;
      if (in_ready && k < 6) begin
        exp_q.push_back(w[k]);
        k++;
      end
    end
    chk("bp_accepts", k, 2);
    chk("bp_in_ready_low", in_ready, 0);
    bp_track = 1;
    stamps.delete();
    out_ready = 1'b1;
    #1;
    if (in_ready && k < 6) begin
      exp_q.push_back(w[k]);
      k++;
    end
    while (k < 6) begin
      send(w[k], 0);
      k++;
    end
    idle(4);
    bp_track = 0;
    chk("bp_out_count", stamps.size(), 6);
    if (stamps.size() == 6) chk("bp_no_gaps", stamps[5] - stamps[0], 5);

    repeat (300) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(make_word(8'($urandom), $urandom_range(0, 2)), 1);
    end
    out_ready = 1'b1;
    idle(6);
    chk("rand_queue_drained", exp_q.size(), 0);

    // Saturation on the 2-bit instance, then clear coinciding with a SEC handshake.
    @(negedge clk);
    clr_cnt = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    clr_cnt = 1'b0;
    repeat (5) send(make_word(8'($urandom), 1), 0);
    idle(4);
    chk("sat_sec_after_5", sec_count_s, 3);
    chk("sec_after_5", sec_count, 5);
    out_ready = 1'b0;
    send(make_word(8'($urandom), 1), 0);
    idle(3);
    @(negedge clk);
    clr_cnt = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("clr_hs_valid_sec", {out_valid, out_sec}, 2'b11);
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    chk("clr_wins_sec", sec_count, 0);
    chk("clr_wins_sat_sec", sec_count_s, 0);

    // Reset with two words in flight and nonzero counters.
    send(make_word(8'($urandom), 2), 0);
    idle(4);
    out_ready = 1'b0;
    send(make_word(8'($urandom), 0), 0);
    send(make_word(8'($urandom), 1), 0);
    idle(3);
    chk("pre_rst_ded_count", ded_count, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_counts", {sec_count, ded_count}, 0);
    chk("midrst_sat_counts", {sec_count_s, ded_count_s}, 0);
    exp_q.delete();
    m_sec = 0;
    m_ded = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("in_ready_post_rst", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("no_stale_word", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
